// File: rtl/mac_rx_fcs_check.sv
// Ethernet RX FCS checker: runs CRC-32 over each frame, strips the 4 FCS bytes,
// and closes every frame with a single status/length pulse.
module mac_rx_fcs_check #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int LEN_W   = 14
) (
    input  logic             rx_clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [7:0]       in_data,
    input  logic             in_sof,
    input  logic             in_eof,
    output logic             out_vld,
    output logic [7:0]       out_data,
    output logic             out_sof,
    output logic             out_eof,
    output logic [3:0]       out_status,
    output logic [LEN_W-1:0] out_len
);

    localparam logic [31:0]      CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0]      RESIDUE  = 32'hDEBB_20E3;
    localparam logic [LEN_W-1:0] MIN_L    = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L    = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_SAT  = {LEN_W{1'b1}};

    typedef enum logic {IDLE, FRAME} state_t;

    state_t           state;
    logic [31:0]      crc;
    logic [LEN_W-1:0] count;
    logic [2:0]       fill;
    logic             first;
    logic [7:0]       dly [4];
    logic             take_byte;

    // Reflected CRC-32, LSB of the byte first; no final inversion so a good
    // frame (data + FCS) leaves the fixed residue.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [3:0] frame_status(input logic abort,
                                                input logic [31:0] c,
                                                input logic [LEN_W-1:0] n);
        return {abort, (n > MAX_L), (n < MIN_L), (c != RESIDUE)};
    endfunction

    assign take_byte = (state == FRAME) && in_vld && !in_eof && !in_sof;

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            crc        <= CRC_INIT;
            count      <= '0;
            fill       <= '0;
            first      <= 1'b0;
            out_vld    <= 1'b0;
            out_data   <= '0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            out_status <= '0;
            out_len    <= '0;
        end else begin
            out_vld    <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            out_status <= '0;
            out_len    <= '0;
            case (state)
                IDLE: begin
                    if (in_sof) begin
                        state <= FRAME;
                        crc   <= CRC_INIT;
                        count <= '0;
                        fill  <= '0;
                        first <= 1'b1;
                    end
                end
                FRAME: begin
                    // A sof without eof aborts the old frame; the new one starts at once.
                    if (in_eof || in_sof) begin
                        out_eof    <= 1'b1;
                        out_status <= frame_status(in_sof && !in_eof, crc, count);
                        out_len    <= count;
                        state      <= in_sof ? FRAME : IDLE;
                        crc        <= CRC_INIT;
                        count      <= '0;
                        fill       <= '0;
                        first      <= 1'b1;
                    end else if (in_vld) begin
                        crc   <= crc_byte(crc, in_data);
                        count <= (count == LEN_SAT) ? count : count + 1'b1;
                        if (fill == 3'd4) begin
                            out_vld  <= 1'b1;
                            out_data <= dly[3];
                            out_sof  <= first;
                            first    <= 1'b0;
                        end else begin
                            fill <= fill + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Delay line holding the last four bytes; they become the FCS at frame end.
    always_ff @(posedge rx_clk) begin
        if (take_byte) begin
            dly[0] <= in_data;
            for (int i = 1; i < 4; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

endmodule
